// File: rtl/rf_port_ctrl_pkg.sv
// Shared widths, defaults and dump FSM state encoding for the register-file port controller.
package rf_port_ctrl_pkg;

    localparam int XLEN            = 32;
    localparam int RFIDX_WIDTH     = 5;
    localparam int RFREG_NUM       = 32;
    localparam int RF_STARVE_LIMIT = 8;

    localparam logic [RFIDX_WIDTH-1:0] RF_LAST_IDX = RFIDX_WIDTH'(RFREG_NUM - 1);

    typedef enum logic [1:0] {
        RFD_IDLE = 2'd0,
        RFD_READ = 2'd1,
        RFD_SEND = 2'd2,
        RFD_DONE = 2'd3
    } rfd_state_e;

endpackage

// File: rtl/rf_port_ctrl_wr_arb.sv
// Write-port arbiter: pipeline writeback wins, but a starved debug write
// eventually raises stall_req and takes the port.
module rf_wr_arb
    import rf_port_ctrl_pkg::*;
#(
    parameter int STARVE_LIMIT = RF_STARVE_LIMIT
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_wb_we,
    input  logic [RFIDX_WIDTH-1:0] i_wb_wa,
    input  logic [XLEN-1:0]        i_wb_wd,
    input  logic                   i_dbg_wr_valid,
    output logic                   o_dbg_wr_ready,
    input  logic [RFIDX_WIDTH-1:0] i_dbg_wa,
    input  logic [XLEN-1:0]        i_dbg_wd,
    output logic                   o_stall_req,
    output logic                   o_rf_we3,
    output logic [RFIDX_WIDTH-1:0] o_rf_wa3,
    output logic [XLEN-1:0]        o_rf_wd3
);

    localparam int CNT_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_LIMIT - 1);

    logic             r_stallReq;
    logic [CNT_W-1:0] r_starveCnt;
    logic             w_dbgGrant;
    logic             w_blocked;

    // Once stall_req is up the pipeline has frozen WB, so debug owns the port.
    always_comb begin
        w_dbgGrant = i_dbg_wr_valid && (r_stallReq || !i_wb_we);
        w_blocked  = i_dbg_wr_valid && !w_dbgGrant;
        o_rf_we3   = 1'b0;
        o_rf_wa3   = i_wb_wa;
        o_rf_wd3   = i_wb_wd;
        if (w_dbgGrant) begin
            o_rf_we3 = 1'b1;
            o_rf_wa3 = i_dbg_wa;
            o_rf_wd3 = i_dbg_wd;
        end else if (i_wb_we) begin
            o_rf_we3 = 1'b1;
        end
    end

    // Counter saturates at the limit; the stall it raises guarantees a grant next cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_starveCnt <= '0;
            r_stallReq  <= 1'b0;
        end else if (w_blocked) begin
            if (r_starveCnt == CNT_LAST) begin
                r_stallReq <= 1'b1;
            end else begin
                r_starveCnt <= r_starveCnt + 1'b1;
            end
        end else begin
            r_starveCnt <= '0;
            r_stallReq  <= 1'b0;
        end
    end

    assign o_dbg_wr_ready = w_dbgGrant;
    assign o_stall_req    = r_stallReq;

endmodule

// File: rtl/rf_port_ctrl.sv
// Register-file port controller: write-port arbitration plus a dump engine that
// streams x0..x31 out through the debug read port on a valid/ready interface.
module rf_port_ctrl
    import rf_port_ctrl_pkg::*;
#(
    parameter int STARVE_LIMIT = RF_STARVE_LIMIT
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_wb_we,
    input  logic [RFIDX_WIDTH-1:0] i_wb_wa,
    input  logic [XLEN-1:0]        i_wb_wd,
    input  logic                   i_dbg_wr_valid,
    output logic                   o_dbg_wr_ready,
    input  logic [RFIDX_WIDTH-1:0] i_dbg_wa,
    input  logic [XLEN-1:0]        i_dbg_wd,
    output logic                   o_stall_req,
    output logic                   o_rf_we3,
    output logic [RFIDX_WIDTH-1:0] o_rf_wa3,
    output logic [XLEN-1:0]        o_rf_wd3,
    output logic [RFIDX_WIDTH-1:0] o_rf_ra3,
    input  logic [XLEN-1:0]        i_rf_reg_data,
    input  logic                   i_dump_start,
    output logic                   o_dump_busy,
    output logic                   o_dump_valid,
    input  logic                   i_dump_ready,
    output logic [RFIDX_WIDTH-1:0] o_dump_idx,
    output logic [XLEN-1:0]        o_dump_data,
    output logic                   o_dump_done
);

    rfd_state_e             r_state;
    rfd_state_e             w_nextState;
    logic [RFIDX_WIDTH-1:0] r_idx;
    logic [RFIDX_WIDTH-1:0] r_ra3;
    logic [RFIDX_WIDTH-1:0] r_dumpIdx;
    logic [XLEN-1:0]        r_dumpData;
    logic                   r_dumpValid;
    logic                   w_startLoad;
    logic                   w_capture;
    logic                   w_accept;
    logic                   w_advance;
    logic                   w_finish;

    rf_wr_arb #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_wr_arb (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_wb_we        (i_wb_we),
        .i_wb_wa        (i_wb_wa),
        .i_wb_wd        (i_wb_wd),
        .i_dbg_wr_valid (i_dbg_wr_valid),
        .o_dbg_wr_ready (o_dbg_wr_ready),
        .i_dbg_wa       (i_dbg_wa),
        .i_dbg_wd       (i_dbg_wd),
        .o_stall_req    (o_stall_req),
        .o_rf_we3       (o_rf_we3),
        .o_rf_wa3       (o_rf_wa3),
        .o_rf_wd3       (o_rf_wd3)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= RFD_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_startLoad = 1'b0;
        w_capture   = 1'b0;
        w_accept    = 1'b0;
        w_advance   = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            RFD_IDLE: begin
                if (i_dump_start) begin
                    w_startLoad = 1'b1;
                    w_nextState = RFD_READ;
                end
            end
            RFD_READ: begin
                w_capture   = 1'b1;
                w_nextState = RFD_SEND;
            end
            RFD_SEND: begin
                if (r_dumpValid && i_dump_ready) begin
                    w_accept = 1'b1;
                    if (r_idx == RF_LAST_IDX) begin
                        w_nextState = RFD_DONE;
                    end else begin
                        w_advance   = 1'b1;
                        w_nextState = RFD_READ;
                    end
                end
            end
            RFD_DONE: begin
                w_finish    = 1'b1;
                w_nextState = RFD_IDLE;
            end
            default: w_nextState = RFD_IDLE;
        endcase
    end

    // x0 is forced to zero here so the dump never depends on the regfile's hardwiring.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_idx       <= '0;
            r_ra3       <= '0;
            r_dumpIdx   <= '0;
            r_dumpData  <= '0;
            r_dumpValid <= 1'b0;
        end else begin
            if (w_startLoad) begin
                r_idx <= '0;
                r_ra3 <= '0;
            end
            if (w_capture) begin
                r_dumpData  <= (r_idx == '0) ? '0 : i_rf_reg_data;
                r_dumpIdx   <= r_idx;
                r_dumpValid <= 1'b1;
            end
            if (w_accept) begin
                r_dumpValid <= 1'b0;
            end
            if (w_advance) begin
                r_idx <= r_idx + 1'b1;
                r_ra3 <= r_idx + 1'b1;
            end
            if (w_finish) begin
                r_ra3 <= '0;
            end
        end
    end

    assign o_rf_ra3     = r_ra3;
    assign o_dump_busy  = (r_state != RFD_IDLE);
    assign o_dump_valid = r_dumpValid;
    assign o_dump_idx   = r_dumpIdx;
    assign o_dump_data  = r_dumpData;
    assign o_dump_done  = (r_state == RFD_DONE);

endmodule

// File: tb/tb_rf_port_ctrl.sv
// Directed bench for rf_port_ctrl with a behavioural regfile that commits on negedge.
module tb_rf_port_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        wbWe;
    logic [4:0]  wbWa;
    logic [31:0] wbWd;
    logic        dbgWrValid;
    logic        dbgWrReady;
    logic [4:0]  dbgWa;
    logic [31:0] dbgWd;
    logic        stallReq;
    logic        rfWe3;
    logic [4:0]  rfWa3;
    logic [31:0] rfWd3;
    logic [4:0]  rfRa3;
    logic [31:0] rfRegData;
    logic        dumpStart;
    logic        dumpBusy;
    logic        dumpValid;
    logic        dumpReady;
    logic [4:0]  dumpIdx;
    logic [31:0] dumpData;
    logic        dumpDone;

    int checks = 0;
    int errors = 0;

    logic [31:0] rfMem [32];
    logic        rfClear;

    always #5 clk = ~clk;

    // Regfile model: write on negedge, x0 hardwired to zero on read.
    always @(negedge clk) begin
        if (rfClear) begin
            for (int i = 0; i < 32; i++) rfMem[i] <= '0;
        end else if (rfWe3 && rfWa3 != 5'd0) begin
            rfMem[rfWa3] <= rfWd3;
        end
    end

    assign rfRegData = (rfRa3 == 5'd0) ? 32'd0 : rfMem[rfRa3];

    rf_port_ctrl #(.STARVE_LIMIT(8)) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_wb_we        (wbWe),
        .i_wb_wa        (wbWa),
        .i_wb_wd        (wbWd),
        .i_dbg_wr_valid (dbgWrValid),
        .o_dbg_wr_ready (dbgWrReady),
        .i_dbg_wa       (dbgWa),
        .i_dbg_wd       (dbgWd),
        .o_stall_req    (stallReq),
        .o_rf_we3       (rfWe3),
        .o_rf_wa3       (rfWa3),
        .o_rf_wd3       (rfWd3),
        .o_rf_ra3       (rfRa3),
        .i_rf_reg_data  (rfRegData),
        .i_dump_start   (dumpStart),
        .o_dump_busy    (dumpBusy),
        .o_dump_valid   (dumpValid),
        .i_dump_ready   (dumpReady),
        .o_dump_idx     (dumpIdx),
        .o_dump_data    (dumpData),
        .o_dump_done    (dumpDone)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                 input logic dv, input logic [4:0] da, input logic [31:0] dd);
        wbWe       = we;
        wbWa       = wa;
        wbWd       = wd;
        dbgWrValid = dv;
        dbgWa      = da;
        dbgWd      = dd;
    endtask

    function automatic logic [31:0] expectedWord(input int i);
        return (i == 0) ? 32'd0 : 32'(i * 3);
    endfunction

    // Runs one dump to completion. In stall mode ready is high one cycle in three,
    // so the handshake phase keeps drifting against the two-cycle word rhythm.
    task automatic runDump(input bit stallMode, output int words, output int busyCycles,
                           output int doneCount, output int holds);
        logic [4:0]  heldIdx;
        logic [31:0] heldData;
        bit          holding;
        bit          finished;
        words      = 0;
        busyCycles = 0;
        doneCount  = 0;
        holds      = 0;
        holding    = 0;
        finished   = 0;
        heldIdx    = '0;
        heldData   = '0;
        dumpStart  = 1'b1;
        dumpReady  = 1'b1;
        tick();
        for (int cyc = 0; cyc < 400; cyc++) begin
            dumpReady = stallMode ? ((cyc % 3) == 2) : 1'b1;
            dumpStart = (!stallMode && cyc == 20);
            #1;
            if (dumpBusy) busyCycles++;
            if (dumpDone) doneCount++;
            if (holding) begin
                checkOutput("holdValid", 32'(dumpValid), 32'd1);
                checkOutput("holdIdx", 32'(dumpIdx), 32'(heldIdx));
                checkOutput("holdData", dumpData, heldData);
                holding = 0;
            end
            if (dumpValid) begin
                if (dumpReady) begin
                    checkOutput("dumpIdx", 32'(dumpIdx), 32'(words));
                    checkOutput("dumpData", dumpData, expectedWord(words));
                    words++;
                end else begin
                    holding  = 1;
                    holds++;
                    heldIdx  = dumpIdx;
                    heldData = dumpData;
                end
            end
            if (!dumpBusy) begin
                finished = 1;
                break;
            end
            tick();
        end
        dumpStart = 1'b0;
        dumpReady = 1'b0;
        checkOutput("dumpFinished", 32'(finished), 32'd1);
    endtask

    int  words;
    int  busyCycles;
    int  doneCount;
    int  holds;
    bit  found;

    initial begin
        reset     = 1'b1;
        rfClear   = 1'b1;
        dumpStart = 1'b0;
        dumpReady = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        repeat (3) tick();
        $display("[TB] reset state");
        checkOutput("rstReady", 32'(dbgWrReady), 32'd0);
        checkOutput("rstStall", 32'(stallReq), 32'd0);
        checkOutput("rstWe3", 32'(rfWe3), 32'd0);
        checkOutput("rstRa3", 32'(rfRa3), 32'd0);
        checkOutput("rstBusy", 32'(dumpBusy), 32'd0);
        checkOutput("rstValid", 32'(dumpValid), 32'd0);
        checkOutput("rstIdx", 32'(dumpIdx), 32'd0);
        checkOutput("rstData", dumpData, 32'd0);
        checkOutput("rstDone", 32'(dumpDone), 32'd0);
        reset   = 1'b0;
        rfClear = 1'b0;
        tick();

        $display("[TB] debug write with idle pipeline");
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF);
        #1;
        checkOutput("dbgReady", 32'(dbgWrReady), 32'd1);
        checkOutput("dbgWe3", 32'(rfWe3), 32'd1);
        checkOutput("dbgWa3", 32'(rfWa3), 32'd5);
        checkOutput("dbgWd3", rfWd3, 32'hDEADBEEF);
        @(negedge clk);
        #1;
        checkOutput("x5Commit", rfMem[5], 32'hDEADBEEF);
        tick();

        applyStimulus(1'b0, 5'd12, 32'hCAFE0001, 1'b0, 5'd3, 32'h0);
        #1;
        checkOutput("idleWe3", 32'(rfWe3), 32'd0);
        checkOutput("idleWa3", 32'(rfWa3), 32'd12);
        checkOutput("idleWd3", rfWd3, 32'hCAFE0001);
        tick();

        $display("[TB] starvation and forced stall");
        applyStimulus(1'b1, 5'd7, 32'h00001234, 1'b1, 5'd9, 32'h00005555);
        #1;
        checkOutput("wbWa3", 32'(rfWa3), 32'd7);
        checkOutput("wbWd3", rfWd3, 32'h00001234);
        for (int k = 0; k < 8; k++) begin
            checkOutput("blockedReady", 32'(dbgWrReady), 32'd0);
            checkOutput("stallEarly", 32'(stallReq), 32'd0);
            tick();
        end
        checkOutput("stallRise", 32'(stallReq), 32'd1);
        checkOutput("stallGrant", 32'(dbgWrReady), 32'd1);
        checkOutput("stallWa3", 32'(rfWa3), 32'd9);
        checkOutput("stallWd3", rfWd3, 32'h00005555);
        tick();
        applyStimulus(1'b1, 5'd7, 32'h00001234, 1'b0, 5'd9, 32'h00005555);
        #1;
        checkOutput("stallFall", 32'(stallReq), 32'd0);
        checkOutput("postReady", 32'(dbgWrReady), 32'd0);
        checkOutput("postWa3", 32'(rfWa3), 32'd7);
        tick();

        applyStimulus(1'b1, 5'd7, 32'h00001234, 1'b1, 5'd9, 32'h00005555);
        repeat (8) tick();
        checkOutput("stallRise2", 32'(stallReq), 32'd1);
        applyStimulus(1'b1, 5'd7, 32'h00001234, 1'b0, 5'd9, 32'h00005555);
        #1;
        checkOutput("dropWa3", 32'(rfWa3), 32'd7);
        tick();
        checkOutput("dropStall", 32'(stallReq), 32'd0);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();

        $display("[TB] preload x1..x31");
        for (int i = 1; i < 32; i++) begin
            applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 32'(i * 3));
            tick();
        end
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFFFFFF);
        #1;
        checkOutput("x0Ready", 32'(dbgWrReady), 32'd1);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();

        $display("[TB] dump with ready held high");
        runDump(1'b0, words, busyCycles, doneCount, holds);
        checkOutput("fullWords", 32'(words), 32'd32);
        checkOutput("fullBusy", 32'(busyCycles), 32'd65);
        checkOutput("fullDone", 32'(doneCount), 32'd1);
        checkOutput("idleRa3", 32'(rfRa3), 32'd0);
        tick();

        $display("[TB] dump with stalling consumer");
        runDump(1'b1, words, busyCycles, doneCount, holds);
        checkOutput("stallWords", 32'(words), 32'd32);
        checkOutput("stallDone", 32'(doneCount), 32'd1);
        checkOutput("stallHolds", 32'(holds > 0), 32'd1);
        tick();

        $display("[TB] reset during dump");
        found     = 0;
        dumpStart = 1'b1;
        dumpReady = 1'b1;
        tick();
        dumpStart = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            #1;
            if (dumpValid && dumpIdx == 5'd10) begin
                found = 1;
                break;
            end
            tick();
        end
        checkOutput("reachIdx10", 32'(found), 32'd1);
        dumpReady = 1'b0;
        reset     = 1'b1;
        tick();
        checkOutput("midRstBusy", 32'(dumpBusy), 32'd0);
        checkOutput("midRstValid", 32'(dumpValid), 32'd0);
        checkOutput("midRstIdx", 32'(dumpIdx), 32'd0);
        checkOutput("midRstData", dumpData, 32'd0);
        checkOutput("midRstRa3", 32'(rfRa3), 32'd0);
        doneCount = 0;
        if (dumpDone) doneCount++;
        tick();
        if (dumpDone) doneCount++;
        reset = 1'b0;
        repeat (3) begin
            tick();
            if (dumpDone) doneCount++;
        end
        checkOutput("midRstNoDone", 32'(doneCount), 32'd0);

        runDump(1'b0, words, busyCycles, doneCount, holds);
        checkOutput("restartWords", 32'(words), 32'd32);
        checkOutput("restartBusy", 32'(busyCycles), 32'd65);
        checkOutput("restartDone", 32'(doneCount), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
